// File: rtl/tremolo_pkg.sv
// Shared constants and types for the tremolo modulator and its LFO.
package tremolo_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned GAIN_W     = 9;
  localparam int unsigned GAIN_UNITY = 256;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } lfo_dir_t;

endpackage

// File: rtl/tremolo_lfo.sv
// Fractional-N tick generator driving a triangle LFO; exposes the top 8 bits of the triangle.
module tremolo_lfo #(
  parameter int unsigned CLK_HZ = tremolo_pkg::CLK_HZ,
  parameter int unsigned LFO_W  = 12
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] frequency,
  input  logic        disabled,
  output logic [7:0]  lfo_level
);
  import tremolo_pkg::*;

  localparam int unsigned ACC_W = 33;
  localparam logic [ACC_W-1:0] THRESH  = ACC_W'(CLK_HZ);
  localparam logic [LFO_W-1:0] TRI_MAX = '1;

  logic [31:0]      r_acc;
  logic [LFO_W-1:0] r_tri;
  lfo_dir_t         r_dir;

  logic [ACC_W-1:0] w_f;
  logic [ACC_W-1:0] w_sum;
  logic             w_tick;
  logic [31:0]      w_acc_next;
  logic [LFO_W-1:0] w_tri_next;
  lfo_dir_t         w_dir_next;

  // Accumulator: step clamped to the clock rate so at most one tick per cycle
  always_comb begin
    w_f        = (frequency > CLK_HZ) ? THRESH : ACC_W'(frequency);
    w_sum      = ACC_W'(r_acc) + w_f;
    w_tick     = 1'b0;
    w_acc_next = 32'(w_sum);
    if (disabled) begin
      w_acc_next = '0;
    end else if (w_sum >= THRESH) begin
      w_tick     = 1'b1;
      w_acc_next = 32'(w_sum - THRESH);
    end
  end

  // Triangle turns around on the tick that reaches an end, never dwelling there
  always_comb begin
    w_tri_next = r_tri;
    w_dir_next = r_dir;
    if (disabled) begin
      w_tri_next = '0;
      w_dir_next = UP;
    end else if (w_tick) begin
      if (r_dir == UP && r_tri == TRI_MAX) begin
        w_dir_next = DOWN;
        w_tri_next = r_tri - LFO_W'(1);
      end else if (r_dir == DOWN && r_tri == '0) begin
        w_dir_next = UP;
        w_tri_next = LFO_W'(1);
      end else if (r_dir == UP) begin
        w_tri_next = r_tri + LFO_W'(1);
      end else begin
        w_tri_next = r_tri - LFO_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc <= '0;
      r_tri <= '0;
      r_dir <= UP;
    end else begin
      r_acc <= w_acc_next;
      r_tri <= w_tri_next;
      r_dir <= w_dir_next;
    end
  end

  generate
    if (LFO_W >= 8) begin : g_level_slice
      assign lfo_level = r_tri[LFO_W-1 -: 8];
    end else begin : g_level_pad
      assign lfo_level = {r_tri, {(8 - LFO_W){1'b0}}};
    end
  endgenerate

endmodule

// File: rtl/tremolo_modulator.sv
// Tremolo: LFO-derived gain applied to each valid sample through a two-stage multiply pipeline.
module tremolo_modulator #(
  parameter int unsigned CLK_HZ   = tremolo_pkg::CLK_HZ,
  parameter int unsigned SAMPLE_W = tremolo_pkg::SAMPLE_W,
  parameter int unsigned LFO_W    = 12,
  parameter int unsigned DEPTH    = 192
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [31:0]                frequency,
  input  logic                       disabled,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       in_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic                       out_valid,
  output logic [7:0]                 lfo_level
);
  import tremolo_pkg::*;

  localparam int unsigned PROD_W = SAMPLE_W + 10;

  logic [7:0]                 w_lfo_level;
  logic [15:0]                w_att_prod;
  logic [15:0]                w_att;
  logic [15:0]                w_gain_full;
  logic [GAIN_W-1:0]          w_gain;
  logic signed [PROD_W-1:0]   w_prod;

  logic                       r_s1_valid;
  logic signed [SAMPLE_W-1:0] r_s1_sample;
  logic [GAIN_W-1:0]          r_s1_gain;

  tremolo_lfo #(
    .CLK_HZ (CLK_HZ),
    .LFO_W  (LFO_W)
  ) u_lfo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .frequency (frequency),
    .disabled  (disabled),
    .lfo_level (w_lfo_level)
  );

  assign lfo_level = w_lfo_level;

  // Gain never exceeds unity, so the pipeline needs no saturation
  assign w_att_prod  = 16'(w_lfo_level) * 16'(DEPTH);
  assign w_att       = w_att_prod >> 8;
  assign w_gain_full = 16'(GAIN_UNITY) - w_att;
  assign w_gain      = disabled ? GAIN_W'(GAIN_UNITY) : GAIN_W'(w_gain_full);

  assign w_prod = PROD_W'(r_s1_sample) * PROD_W'($signed({1'b0, r_s1_gain}));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_valid  <= 1'b0;
      r_s1_sample <= '0;
      r_s1_gain   <= '0;
      out_valid   <= 1'b0;
      out_sample  <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sample <= in_sample;
        r_s1_gain   <= w_gain;
      end
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_sample <= SAMPLE_W'(w_prod >>> 8);
      end
    end
  end

endmodule

// File: tb/tb_tremolo_modulator.sv
// Directed checks of the tremolo modulator: reset, bypass, tick rate, triangle shape, gain, re-enable.
module tb_tremolo_modulator;

  logic               clk;
  logic               rst_n;
  logic [31:0]        frequency;
  logic               disabled;
  logic signed [23:0] in_sample;
  logic               in_valid;
  logic signed [23:0] out_sample;
  logic               out_valid;
  logic [7:0]         lfo_level;

  logic [31:0]        f4;
  logic               dis4;
  logic signed [23:0] in4;
  logic               iv4;
  logic signed [23:0] out4;
  logic               ov4;
  logic [7:0]         lfo4;

  int n_checks;
  int n_pass;

  tremolo_modulator u_dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .frequency  (frequency),
    .disabled   (disabled),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .lfo_level  (lfo_level)
  );

  tremolo_modulator #(
    .CLK_HZ (500_000),
    .LFO_W  (4)
  ) u_dut4 (
    .CLK        (clk),
    .RST_N      (rst_n),
    .frequency  (f4),
    .disabled   (dis4),
    .in_sample  (in4),
    .in_valid   (iv4),
    .out_sample (out4),
    .out_valid  (ov4),
    .lfo_level  (lfo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; disabled = 1'b1; frequency = 32'd0; in_valid = 1'b0; in_sample = '0;
    dis4 = 1'b1; f4 = 32'd0; iv4 = 1'b0; in4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({out_valid, out_sample, lfo_level} !== {1'b0, 24'sd0, 8'd0})
      $display("FAIL reset_state: got v=%0b s=%0d l=%0d, required 0 0 0", out_valid, out_sample, lfo_level);
    else n_pass++;
    in_valid = 1'b1; in_sample = 24'sd5000;
    @(posedge clk); @(negedge clk);
    in_sample = 24'sd6000;
    @(posedge clk); @(negedge clk);
    in_sample = 24'sd7000;
    n_checks++;
    if (out_valid !== 1'b1 || out_sample !== 24'sd5000)
      $display("FAIL reset_prefill: got v=%0b s=%0d, required 1 5000", out_valid, out_sample);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sample !== 24'sd0)
      $display("FAIL reset_async: got v=%0b s=%0d, required 0 0", out_valid, out_sample);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; disabled = 1'b0; frequency = 32'd19531;
    in_valid = 1'b1; in_sample = 24'sd12345;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_latency: got out_valid=%0b one cycle after in_valid, required 0", out_valid);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sample !== 24'sd12345 || lfo_level !== 8'd0)
      $display("FAIL reset_first_unity: got v=%0b s=%0d l=%0d, required 1 12345 0", out_valid, out_sample, lfo_level);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic signed [23:0] vec [3];
    vec[0] = -24'sd8388608; vec[1] = 24'sd8388607; vec[2] = 24'sd1000;
    @(negedge clk);
    disabled = 1'b1; frequency = 32'd50_000_000;
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i < 3);
      in_sample = (i < 3) ? vec[i] : 24'sd0;
      @(posedge clk); @(negedge clk);
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_sample !== vec[i-1] || lfo_level !== 8'd0)
          $display("FAIL bypass_%0d: got v=%0b s=%0d l=%0d, required 1 %0d 0", i - 1, out_valid, out_sample, lfo_level, vec[i-1]);
        else n_pass++;
      end
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_sample !== 24'sd1000)
      $display("FAIL bypass_hold: got v=%0b s=%0d, required 0 1000", out_valid, out_sample);
    else n_pass++;
  endtask

  task automatic count_ticks(input logic [31:0] f, input int cycles, output int cnt);
    @(negedge clk);
    dis4 = 1'b1; f4 = f;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dis4 = 1'b0;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      if (u_dut4.u_lfo.w_tick === 1'b1) cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_tick_rate();
    int cnt;
    count_ticks(32'd19531, 5000, cnt);
    n_checks++;
    if (cnt != 195 && cnt != 196)
      $display("FAIL tick_rate_19531: got %0d ticks, required 195 or 196", cnt);
    else n_pass++;
    count_ticks(32'd0, 1000, cnt);
    n_checks++;
    if (cnt != 0)
      $display("FAIL tick_rate_zero: got %0d ticks, required 0", cnt);
    else n_pass++;
    count_ticks(32'd60_000_000, 100, cnt);
    n_checks++;
    if (cnt != 100)
      $display("FAIL tick_rate_clamp: got %0d ticks, required 100", cnt);
    else n_pass++;
  endtask

  task automatic test_triangle();
    int m;
    logic [3:0] exp_tri;
    @(negedge clk);
    dis4 = 1'b1; f4 = 32'd500_000;
    @(posedge clk); @(negedge clk);
    dis4 = 1'b0;
    for (int k = 0; k < 62; k++) begin
      m = k % 30;
      exp_tri = (m <= 15) ? 4'(m) : 4'(30 - m);
      n_checks++;
      if (lfo4 !== {exp_tri, 4'b0000})
        $display("FAIL triangle_step_%0d: got lfo=%0d, required %0d", k, lfo4, {exp_tri, 4'b0000});
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (ov4 !== 1'b0 || out4 !== 24'sd0)
      $display("FAIL triangle_idle_out: got v=%0b s=%0d, required 0 0", ov4, out4);
    else n_pass++;
  endtask

  task automatic test_gain();
    @(negedge clk);
    disabled = 1'b1; frequency = 32'd50_000_000; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    disabled = 1'b0;
    repeat (2048) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (lfo_level !== 8'd128)
      $display("FAIL gain_mid_level: got %0d, required 128", lfo_level);
    else n_pass++;
    in_valid = 1'b1; in_sample = 24'sd1000;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sample !== 24'sd625)
      $display("FAIL gain_mid: got v=%0b s=%0d, required 1 625", out_valid, out_sample);
    else n_pass++;
    repeat (2040) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (lfo_level !== 8'd255)
      $display("FAIL gain_peak_level: got %0d, required 255", lfo_level);
    else n_pass++;
    in_valid = 1'b1; in_sample = 24'sd1024;
    @(posedge clk); @(negedge clk);
    in_sample = -24'sd1024;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sample !== 24'sd260)
      $display("FAIL gain_peak_pos: got v=%0b s=%0d, required 1 260", out_valid, out_sample);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sample !== -24'sd260)
      $display("FAIL gain_peak_neg: got v=%0b s=%0d, required 1 -260", out_valid, out_sample);
    else n_pass++;
  endtask

  task automatic test_reenable();
    @(negedge clk);
    disabled = 1'b1; frequency = 32'd50_000_000; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    disabled = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (lfo_level !== 8'd62)
      $display("FAIL reenable_level: got %0d, required 62", lfo_level);
    else n_pass++;
    in_valid = 1'b1; in_sample = 24'sd256;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; disabled = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sample !== 24'sd210)
      $display("FAIL reenable_inflight: got v=%0b s=%0d, required 1 210", out_valid, out_sample);
    else n_pass++;
    n_checks++;
    if (lfo_level !== 8'd0 || u_dut.u_lfo.r_acc !== 32'd0)
      $display("FAIL reenable_cleared: got l=%0d acc=%0d, required 0 0", lfo_level, u_dut.u_lfo.r_acc);
    else n_pass++;
    disabled = 1'b0;
    in_valid = 1'b1; in_sample = 24'sd300;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sample !== 24'sd300)
      $display("FAIL reenable_unity: got v=%0b s=%0d, required 1 300", out_valid, out_sample);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_back_to_back();
    test_tick_rate();
    test_triangle();
    test_gain();
    test_reenable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
